// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Purpose  : Shared constants and types for the sequential restoring divider
//            and its carry-select subtractor.
// Contents : c_def_width  - default operand/result width
//            c_cnt_w      - step counter width for the default width
//            c_st_*       - 2-bit FSM state encodings (IDLE/RUN/DONE)
//            state_t      - FSM state type built on the encodings above
//            cnt_width()  - counter width for an arbitrary operand width
// Revision : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam int c_def_width = 8;
    localparam int c_cnt_w     = $clog2(c_def_width);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = c_st_idle,
        S_RUN  = c_st_run,
        S_DONE = c_st_done
    } state_t;

    // A one-bit operand still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : arith_pkg
`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider_if
// Purpose  : Request/result bundle between a client and the divider.
// Signals  : start       - request a division (client -> divider)
//            dividend    - unsigned dividend, WIDTH bits
//            divisor     - unsigned divisor, WIDTH bits
//            busy        - division in progress (divider -> client)
//            done        - one-cycle completion pulse
//            quotient    - result quotient, held until next completion
//            remainder   - result remainder, held until next completion
//            div_by_zero - last division had a zero divisor
// Modports : master (client side), slave (divider side)
// Revision : 1.0 - initial release
// ============================================================================
interface seq_restoring_divider_if
    import arith_pkg::*;
#(
    parameter int WIDTH = c_def_width
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : seq_restoring_divider_if
`default_nettype wire

// File: rtl/seq_restoring_divider_csel_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : csel_subtractor
// Purpose  : Combinational N-bit subtractor, diff = a - b computed as
//            a + ~b + 1. The lower half is a ripple chain; the upper half is
//            evaluated for both carry-in values and picked by the lower carry.
// Ports    : i_a      - minuend, N bits
//            i_b      - subtrahend, N bits
//            o_diff   - (a - b) mod 2^N
//            o_borrow - 1 when a < b (inverse of the final carry)
// Revision : 1.0 - initial release
// ============================================================================
module csel_subtractor #(
    parameter int N = 9
) (
    input  wire logic [N-1:0] i_a,
    input  wire logic [N-1:0] i_b,
    output logic      [N-1:0] o_diff,
    output logic              o_borrow
);

    localparam int c_lo = N / 2;
    localparam int c_hi = N - c_lo;

    logic [N-1:0]    w_nb;
    logic [c_lo:0]   w_c;
    logic [c_hi:0]   w_hi_c0;
    logic [c_hi:0]   w_hi_c1;
    logic [c_hi:0]   w_hi_sel;

    assign w_nb   = ~i_b;
    // The +1 of the two's complement enters as the ripple carry-in.
    assign w_c[0] = 1'b1;

    for (genvar gi = 0; gi < c_lo; gi++) begin : g_ripple
        assign o_diff[gi]  = i_a[gi] ^ w_nb[gi] ^ w_c[gi];
        assign w_c[gi + 1] = (i_a[gi] & w_nb[gi]) | (w_c[gi] & (i_a[gi] ^ w_nb[gi]));
    end

    // Both upper-half candidates settle in parallel with the ripple chain.
    assign w_hi_c0 = {1'b0, i_a[N-1:c_lo]} + {1'b0, w_nb[N-1:c_lo]};
    assign w_hi_c1 = {1'b0, i_a[N-1:c_lo]} + {1'b0, w_nb[N-1:c_lo]} + (c_hi + 1)'(1);

    assign w_hi_sel        = w_c[c_lo] ? w_hi_c1 : w_hi_c0;
    assign o_diff[N-1:c_lo] = w_hi_sel[c_hi-1:0];
    assign o_borrow        = ~w_hi_sel[c_hi];

endmodule : csel_subtractor
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider
// Purpose  : Multi-cycle unsigned restoring divider, one quotient bit per
//            clock. quotient = dividend / divisor, remainder = dividend %
//            divisor. A zero divisor completes immediately with an all-ones
//            quotient, remainder = dividend and div_by_zero set.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous, active-high reset
//            bus  - slave side of seq_restoring_divider_if
//                   (start/dividend/divisor in; busy/done/results out)
// Revision : 1.0 - initial release
// ============================================================================
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = c_def_width
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seq_restoring_divider_if.slave  bus
);

    localparam int c_k_w = cnt_width(WIDTH);
    localparam logic [c_k_w-1:0] c_k_last = c_k_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH:0]     r_p;          // partial remainder
    logic [WIDTH-1:0]   r_q;          // dividend shifting out / quotient in
    logic [WIDTH-1:0]   r_divisor;
    logic [c_k_w-1:0]   r_k;

    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic [WIDTH:0]     w_t;
    logic [WIDTH:0]     w_d;
    logic               w_borrow;
    logic [WIDTH:0]     w_p_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic               w_unused;

    // ------------------------------------------------------------------
    // One restoring step: shift the next dividend bit into the partial
    // remainder and try to take the divisor out of it.
    // ------------------------------------------------------------------
    assign w_t = {r_p[WIDTH-1:0], r_q[WIDTH-1]};

    csel_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a      (w_t),
        .i_b      ({1'b0, r_divisor}),
        .o_diff   (w_d),
        .o_borrow (w_borrow)
    );

    assign w_p_nxt = w_borrow ? w_t : w_d;
    assign w_q_nxt = {r_q[WIDTH-2:0], ~w_borrow};
    assign w_last  = (r_k == c_k_last);

    // P stays below the divisor, so its top bit (and the subtractor's top
    // result bit on a successful step) is always zero and never consumed.
    assign w_unused = &{1'b0, r_p[WIDTH], w_d[WIDTH]};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and status decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p       <= '0;
            r_q       <= '0;
            r_divisor <= '0;
            r_k       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_p       <= '0;
                        r_q       <= bus.dividend;
                        r_divisor <= bus.divisor;
                        r_k       <= '0;
                    end
                end
                S_RUN: begin
                    r_p <= w_p_nxt;
                    r_q <= w_q_nxt;
                    r_k <= r_k + c_k_w'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result registers: loaded on the edge that enters DONE, so they are
    // already valid in the done cycle and hold until the next completion.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.start && (bus.divisor == '0)) begin
                r_quotient    <= '1;
                r_remainder   <= bus.dividend;
                r_div_by_zero <= 1'b1;
            end else if ((r_state == S_RUN) && w_last) begin
                r_quotient    <= w_q_nxt;
                r_remainder   <= w_p_nxt[WIDTH-1:0];
                r_div_by_zero <= 1'b0;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule : seq_restoring_divider
`default_nettype wire

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Multi-cycle unsigned divider, the inverse of the lab adder datapath. It computes `quotient = dividend / divisor` and `remainder = dividend % divisor` by restoring division, one quotient bit per clock. Each trial subtraction is done by a carry-select subtractor sub-module. The block sits beside the adder blocks as the arithmetic unit for operations that cannot finish in a single combinational pass.

## Interface
- `WIDTH`, default 8: operand and result width in bits.
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `start`: input, 1 bit. Requests a division. Sampled only in IDLE.
- `dividend`: input, `WIDTH` bits. Unsigned; captured on the accepted start.
- `divisor`: input, `WIDTH` bits. Unsigned; captured on the accepted start.
- `busy`: output, 1 bit. High while a division is in progress (RUN state).
- `done`: output, 1 bit. One-cycle pulse; results are valid from this cycle onward.
- `quotient`: output, `WIDTH` bits. Result; held until the next accepted start.
- `remainder`: output, `WIDTH` bits. Result; held until the next accepted start.
- `div_by_zero`: output, 1 bit. Set with `done` when divisor was 0; held with results.

## Operation
- FSM states:
  - IDLE: `start`=1 → capture operands; clear P, clear k, Q = dividend → RUN. If divisor = 0, go to DONE instead.
  - RUN: perform one step per cycle; after step k = WIDTH-1 → DONE.
  - DONE: `done`=1 for this cycle only → IDLE.
- Partial remainder register P is WIDTH+1 bits. Quotient/shift register Q is WIDTH bits. Step counter k runs 0..WIDTH-1.
- One step:
  - T = {P[WIDTH-1:0], Q[WIDTH-1]}.
  - Compute D = T − {1'b0, divisor} with the subtractor.
  - If no borrow: P = D and Q = {Q[WIDTH-2:0], 1'b1}.
  - If borrow: P = T and Q = {Q[WIDTH-2:0], 1'b0}.
- On completion: `quotient` = Q, `remainder` = P[WIDTH-1:0]. P never exceeds divisor−1, so truncating to WIDTH bits is lossless.
- Divide by zero: `quotient` = all ones, `remainder` = dividend, `div_by_zero` = 1. No RUN cycles.
- `start` in RUN or DONE is ignored; the request is not queued.
- Operand inputs may change freely after the accepting edge.
- `rst` at any time, including mid-RUN, forces IDLE immediately and clears everything. The aborted operation produces no `done`.
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, FSM=IDLE, P=0, Q=0, k=0.

## Timing
- Start accepted at edge E0.
- `busy` is high from after E0 through the WIDTH RUN cycles.
- DONE is entered at edge E0+WIDTH. `done` is high for exactly that one cycle; `busy` is low in DONE.
- Normal latency: `done` asserted WIDTH cycles after the accepting edge (8 for the default).
- Divide-by-zero latency: `done` is high in the cycle after E0, and `busy` never rises.
- Back-to-back rate: the next `start` is accepted in IDLE, one cycle after DONE. Throughput is one division per WIDTH+2 cycles.
- Outputs `quotient`, `remainder` and `div_by_zero` update at the edge entering DONE and are stable until the next DONE.
- The subtractor path is purely combinational within one cycle; no internal pipelining.

## Structure
- Shared package `arith_pkg`:
  - default `WIDTH` constant.
  - FSM state encoding IDLE/RUN/DONE, as a 2-bit localparam set.
  - counter width `$clog2(WIDTH)`.
- Sub-module `csel_subtractor`:
  - inputs: parameterised width (WIDTH+1), a, b.
  - outputs: diff, borrow.
  - Implements a + ~b + 1, lower half ripple. Upper half is computed twice (carry-in 0 and 1) and selected by the lower-half carry.
  - borrow = ~carry_out.
- The divider top holds the FSM, P/Q/k registers and output registers.

## Test plan
- 100 / 7 → `done` 8 cycles after start; `quotient`=14, `remainder`=2, `div_by_zero`=0; `busy` high exactly 8 cycles.
- 255 / 1 → 255 r 0. 5 / 9 → 0 r 5. 255 / 255 → 1 r 0. Run back-to-back, each start issued the cycle after `done`.
- 37 / 0 → `done` the cycle after start; `quotient`=8'hFF, `remainder`=37, `div_by_zero`=1; `busy` never high.
- 200 / 3 started; `start` with 9 / 2 pulsed at cycle 4 of RUN → ignored; result 66 r 2. Results hold steady for 10 idle cycles.
- 200 / 3 started; `rst` asserted mid-cycle at RUN step 4 → all outputs 0 immediately, no `done`. Then 50 / 6 → 8 r 2.
- `csel_subtractor` standalone, exhaustive 9-bit a, b → diff = (a−b) mod 512 and borrow = (a<b) for all pairs.
